// File: rtl/taillight_pkg.sv
// Shared constants for the taillight mode controller and the downstream blinker.
package taillight_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 240_000;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_HAZARD = 3'd1,
    MODE_LEFT   = 3'd2,
    MODE_RIGHT  = 3'd3,
    MODE_BRAKE  = 3'd4
  } mode_t;

  typedef enum logic {
    HZ_OFF = 1'b0,
    HZ_ON  = 1'b1
  } hz_state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one key.
module key_debounce
  import taillight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The counter only advances while the sample disagrees and is cleared on
  // every flip, so it tops out at CNT_TC and cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/taillight_mode_ctrl.sv
// Taillight mode selector: debounced levers/switches, hazard latch and
// priority encoding into a registered mode code for the blinker.
//
//   state  | meaning
//   HZ_OFF | hazard flasher inactive
//   HZ_ON  | hazard flasher latched on (toggled by each hazard press)
module taillight_mode_ctrl
  import taillight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_brake,
  input  logic       key_hazard,
  output logic [2:0] mode,
  output logic       mode_chg,
  output logic       conflict
);

  logic      left;
  logic      right;
  logic      brake;
  logic      hazard;
  logic      hazard_d;
  hz_state_t hz_state;
  mode_t     next_mode;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .raw(key_left), .level(left)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .raw(key_right), .level(right)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_brake (
    .clk(clk), .rst_n(rst_n), .raw(key_brake), .level(brake)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
    .clk(clk), .rst_n(rst_n), .raw(key_hazard), .level(hazard)
  );

  always_comb begin
    next_mode = MODE_OFF;
    if (brake)                 next_mode = MODE_BRAKE;
    else if (hz_state == HZ_ON) next_mode = MODE_HAZARD;
    else if (left && right)    next_mode = MODE_OFF;
    else if (left)             next_mode = MODE_LEFT;
    else if (right)            next_mode = MODE_RIGHT;
  end

  // Brake only masks the hazard mode; it never touches the latch itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_state <= HZ_OFF;
      hazard_d <= 1'b0;
      mode     <= MODE_OFF;
      mode_chg <= 1'b0;
      conflict <= 1'b0;
    end else begin
      hazard_d <= hazard;
      if (hazard && !hazard_d) begin
        hz_state <= (hz_state == HZ_ON) ? HZ_OFF : HZ_ON;
      end
      mode     <= next_mode;
      mode_chg <= (next_mode != mode_t'(mode));
      conflict <= left && right;
    end
  end

endmodule

// File: tb/tb_taillight_mode_ctrl.sv
// Bench for taillight_mode_ctrl: directed scenarios plus random key activity,
// all checked against a sliding-window reference model.
module tb_taillight_mode_ctrl;

  localparam int DC = 16;
  localparam int HL = DC + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_brake = 1'b0;
  logic       key_hazard = 1'b0;
  logic [2:0] mode;
  logic       mode_chg;
  logic       conflict;

  taillight_mode_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_left(key_left), .key_right(key_right),
    .key_brake(key_brake), .key_hazard(key_hazard),
    .mode(mode), .mode_chg(mode_chg), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_chg = 0;

  // Reference: key order left, right, brake, hazard; history index 0 = newest raw sample.
  logic m_hist [4][HL];
  logic m_lvl  [4];
  logic m_hz;
  logic m_hz_rise;
  int   m_mode;
  logic m_chg;
  logic m_conf;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_lvl[k] = 1'b0;
      for (int i = 0; i < HL; i++) m_hist[k][i] = 1'b0;
    end
    m_hz = 1'b0; m_hz_rise = 1'b0; m_mode = 0; m_chg = 1'b0; m_conf = 1'b0;
  endtask

  task automatic model_edge();
    logic raw [4];
    int   nm;
    logic all_diff;
    raw[0] = key_left; raw[1] = key_right; raw[2] = key_brake; raw[3] = key_hazard;
    if (m_lvl[2])                nm = 4;
    else if (m_hz)               nm = 1;
    else if (m_lvl[0] && m_lvl[1]) nm = 0;
    else if (m_lvl[0])           nm = 2;
    else if (m_lvl[1])           nm = 3;
    else                         nm = 0;
    m_chg  = (nm != m_mode);
    m_conf = m_lvl[0] && m_lvl[1];
    m_mode = nm;
    if (m_hz_rise) m_hz = !m_hz;
    m_hz_rise = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = HL - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = raw[k];
      // A level is accepted once the DC oldest samples (behind the 2-flop sync) all disagree.
      all_diff = 1'b1;
      for (int i = 2; i < HL; i++) if (m_hist[k][i] == m_lvl[k]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[k] = !m_lvl[k];
        if (k == 3 && m_lvl[k]) m_hz_rise = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk("mode", int'(mode), m_mode);
    chk("mode_chg", int'(mode_chg), int'(m_chg));
    chk("conflict", int'(conflict), int'(m_conf));
    if (mode_chg) n_chg++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    steps(n);
    rst_n = 1'b1;
  endtask

  task automatic all_keys_low();
    key_left = 1'b0; key_right = 1'b0; key_brake = 1'b0; key_hazard = 1'b0;
  endtask

  int base;

  initial begin
    model_reset();
    @(negedge clk);
    steps(3);
    chk("rst_mode", int'(mode), 0);
    chk("rst_conflict", int'(conflict), 0);
    rst_n = 1'b1;

    // Clean left edge: mode 2 and a single pulse 19 cycles later.
    base = n_chg;
    key_left = 1'b1;
    steps(18);
    chk("left_before19", int'(mode), 0);
    step();
    chk("left_mode19", int'(mode), 2);
    chk("left_pulse19", int'(mode_chg), 1);
    step();
    chk("left_pulse_once", int'(mode_chg), 0);
    chk("left_pulse_count", n_chg - base, 1);
    key_left = 1'b0;
    steps(25);
    do_reset(2);

    // Brake bouncing with a 10-cycle period never qualifies.
    base = n_chg;
    for (int i = 0; i < 200; i++) begin
      key_brake = ((i % 10) < 5);
      step();
    end
    key_brake = 1'b0;
    steps(30);
    chk("bounce_mode", int'(mode), 0);
    chk("bounce_pulses", n_chg - base, 0);

    // Hazard presses toggle the latch on and back off.
    base = n_chg;
    key_hazard = 1'b1; steps(30); key_hazard = 1'b0; steps(40);
    chk("hz_on_mode", int'(mode), 1);
    chk("hz_on_pulses", n_chg - base, 1);
    base = n_chg;
    key_hazard = 1'b1; steps(30); key_hazard = 1'b0; steps(40);
    chk("hz_off_mode", int'(mode), 0);
    chk("hz_off_pulses", n_chg - base, 1);

    // Brake overrides hazard without clearing the latch.
    key_hazard = 1'b1; steps(30); key_hazard = 1'b0; steps(40);
    chk("hzb_start", int'(mode), 1);
    key_brake = 1'b1; steps(30);
    chk("hzb_brake", int'(mode), 4);
    key_brake = 1'b0; steps(30);
    chk("hzb_back", int'(mode), 1);
    do_reset(2);

    // Left and right together is a conflict.
    key_left = 1'b1; key_right = 1'b1; steps(30);
    chk("conf_mode", int'(mode), 0);
    chk("conf_flag", int'(conflict), 1);
    key_right = 1'b0; steps(25);
    chk("conf_rel_mode", int'(mode), 2);
    chk("conf_rel_flag", int'(conflict), 0);
    all_keys_low(); steps(25);
    do_reset(2);

    // Reset mid-debounce discards progress; held key re-qualifies from release.
    key_right = 1'b1;
    steps(8);
    base = n_chg;
    do_reset(3);
    steps(18);
    chk("rr_quiet_mode", int'(mode), 0);
    chk("rr_no_pulse", n_chg - base, 0);
    step();
    chk("rr_mode19", int'(mode), 3);
    chk("rr_pulse19", int'(mode_chg), 1);
    all_keys_low(); steps(25);

    // Random key activity with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(23, 0) == 0) key_left   = ~key_left;
      if ($urandom_range(23, 0) == 0) key_right  = ~key_right;
      if ($urandom_range(31, 0) == 0) key_brake  = ~key_brake;
      if ($urandom_range(19, 0) == 0) key_hazard = ~key_hazard;
      if ($urandom_range(999, 0) == 0) do_reset($urandom_range(4, 1));
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
